// File: rtl/lcd_fb_if.sv
// ----------------------------------------------------------------------------
// lcd_fb_if
// Purpose : groups the pixel-input, display-sync and frame-buffer write
//           signals of lcd_fb_ctrl into one bundle.
// Signals : ce, pix_data, mode, lcd_on, disp_vsync  (PPU/display -> ctrl)
//           wr_en, wr_addr, wr_data                 (ctrl -> frame buffer)
//           disp_bank, swap_pend, drop_cnt          (ctrl status)
// Modports: master = PPU/display side (drives inputs, observes outputs)
//           slave  = lcd_fb_ctrl
// ----------------------------------------------------------------------------
interface lcd_fb_if;
    logic        ce;
    logic [14:0] pix_data;
    logic [1:0]  mode;
    logic        lcd_on;
    logic        disp_vsync;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [14:0] wr_data;
    logic        disp_bank;
    logic        swap_pend;
    logic [7:0]  drop_cnt;

    modport master (
        output ce, pix_data, mode, lcd_on, disp_vsync,
        input  wr_en, wr_addr, wr_data, disp_bank, swap_pend, drop_cnt
    );

    modport slave (
        input  ce, pix_data, mode, lcd_on, disp_vsync,
        output wr_en, wr_addr, wr_data, disp_bank, swap_pend, drop_cnt
    );
endinterface

// File: rtl/lcd_fb_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_fb_ctrl
// Purpose : double-buffered frame-buffer writer for a 160x144 LCD. Pixels
//           from the PPU are written to the back bank (~disp_bank); a
//           complete frame is swapped to the display on disp_vsync.
//           Incomplete frames and frames overrun while a swap is pending
//           are counted in a saturating drop counter.
// Ports   : clk      - system clock
//           reset_n  - synchronous active-low reset
//           bus      - lcd_fb_if.slave (pixel input, sync, write port, status)
// Config  : define LCD_FB_BLANK_FILL_EN to blank the back bank with
//           FILL_COLOR and swap it in when the LCD is switched off.
//           Without it, switching the LCD off just returns to SYNC.
// ----------------------------------------------------------------------------
module lcd_fb_ctrl #(
    parameter int          PIXELS     = 23040,
    parameter logic [14:0] FILL_COLOR = 15'h7FFF
) (
    input  logic     clk,
    input  logic     reset_n,
    lcd_fb_if.slave  bus
);

`ifdef LCD_FB_BLANK_FILL_EN
    typedef enum logic [1:0] {SYNC, WRITE, PEND, FILL} state_t;
    localparam logic [14:0] PIX_LAST = 15'(PIXELS - 1);
`else
    typedef enum logic [1:0] {SYNC, WRITE, PEND} state_t;
    // FILL_COLOR only matters when the blank fill is built in.
    logic unused_fill_color;
    assign unused_fill_color = ^FILL_COLOR;
`endif

    localparam logic [14:0] PIX_MAX = 15'(PIXELS);

    state_t      state_q,     state_d;
    logic [14:0] pix_cnt_q,   pix_cnt_d;
    logic        disp_bank_q, disp_bank_d;
    logic [7:0]  drop_cnt_q,  drop_cnt_d;
    logic        wr_en_q,     wr_en_d;
    logic [15:0] wr_addr_q,   wr_addr_d;
    logic [14:0] wr_data_q,   wr_data_d;
    logic        vblank_q;
    logic        lcd_on_q;

    logic vblank, vblank_rise, vblank_exit, lcd_fall, drop_inc;

    assign vblank      = (bus.mode == 2'b01);
    assign vblank_rise = vblank & ~vblank_q;
    assign vblank_exit = ~vblank & vblank_q;
    assign lcd_fall    = lcd_on_q & ~bus.lcd_on;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= SYNC;
            pix_cnt_q   <= '0;
            disp_bank_q <= 1'b0;
            drop_cnt_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            vblank_q    <= 1'b0;
            lcd_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            disp_bank_q <= disp_bank_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            vblank_q    <= vblank;
            lcd_on_q    <= bus.lcd_on;
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        disp_bank_d = disp_bank_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        drop_inc    = 1'b0;

        case (state_q)
            SYNC: begin
                if (vblank_exit && bus.lcd_on) begin
                    pix_cnt_d = '0;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (vblank_rise) begin
                    if (pix_cnt_q == PIX_MAX) begin
                        // A vsync coinciding with frame completion swaps
                        // immediately; the frame never shows as pending.
                        if (bus.disp_vsync) begin
                            disp_bank_d = ~disp_bank_q;
                            state_d     = SYNC;
                        end else begin
                            state_d     = PEND;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = SYNC;
                    end
                end else if (bus.ce && (pix_cnt_q != PIX_MAX)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~disp_bank_q, pix_cnt_q};
                    wr_data_d = bus.pix_data;
                    pix_cnt_d = pix_cnt_q + 15'd1;
                end
            end
            PEND: begin
                // Each vblank entry here is a frame the PPU rendered that
                // could not be captured because the back bank is full.
                if (vblank_rise) begin
                    drop_inc = 1'b1;
                end
                if (bus.disp_vsync) begin
                    disp_bank_d = ~disp_bank_q;
                    state_d     = SYNC;
                end
            end
`ifdef LCD_FB_BLANK_FILL_EN
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {~disp_bank_q, pix_cnt_q};
                wr_data_d = FILL_COLOR;
                if (pix_cnt_q == PIX_LAST) begin
                    disp_bank_d = ~disp_bank_q;
                    state_d     = SYNC;
                end else begin
                    pix_cnt_d = pix_cnt_q + 15'd1;
                end
            end
`endif
            default: state_d = SYNC;
        endcase

        // LCD switch-off overrides whatever the state decided: no write,
        // no swap, no drop count. A fill already running is not restarted.
`ifdef LCD_FB_BLANK_FILL_EN
        if (lcd_fall && (state_q != FILL)) begin
            wr_en_d     = 1'b0;
            drop_inc    = 1'b0;
            disp_bank_d = disp_bank_q;
            pix_cnt_d   = '0;
            state_d     = FILL;
        end
`else
        if (lcd_fall) begin
            wr_en_d     = 1'b0;
            drop_inc    = 1'b0;
            disp_bank_d = disp_bank_q;
            state_d     = SYNC;
        end
`endif

        drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1
                                                         : drop_cnt_q;
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.disp_bank = disp_bank_q;
    assign bus.swap_pend = (state_q == PEND);
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_lcd_fb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_fb_ctrl
// Purpose : directed self-checking bench for lcd_fb_ctrl (default 160x144
//           frame). Define LCD_FB_BLANK_FILL_EN to build both bench and
//           design with the blank-fill behaviour.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_fb_ctrl;
    localparam int NPIX = 23040;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    lcd_fb_if bus_if ();

    lcd_fb_ctrl #(.PIXELS(NPIX), .FILL_COLOR(15'h7FFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        bus_if.ce         = 1'b0;
        bus_if.pix_data   = '0;
        bus_if.mode       = 2'b00;
        bus_if.lcd_on     = 1'b1;
        bus_if.disp_vsync = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Vblank for one cycle, then active display: controller ends in WRITE.
    task automatic start_frame();
        bus_if.mode = 2'b01;
        step();
        bus_if.mode = 2'b00;
        step();
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus_if.ce         = 1'b1;
        bus_if.pix_data   = 15'h5555;
        bus_if.mode       = 2'b00;
        bus_if.lcd_on     = 1'b1;
        bus_if.disp_vsync = 1'b0;
        step();
        step();
        checks++;
        if (bus_if.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus_if.wr_en); end
        checks++;
        if (bus_if.wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0000", bus_if.wr_addr); end
        checks++;
        if (bus_if.wr_data !== 15'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0000", bus_if.wr_data); end
        checks++;
        if (bus_if.disp_bank !== 1'b0 || bus_if.swap_pend !== 1'b0) begin
            errors++; $display("FAIL reset_bank_pend: got bank=%b pend=%b want 0/0", bus_if.disp_bank, bus_if.swap_pend);
        end
        checks++;
        if (bus_if.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus_if.drop_cnt); end
        // ce keeps pulsing after release: SYNC must ignore it.
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (bus_if.wr_en !== 1'b0) begin errors++; $display("FAIL sync_ignores_ce: got wr_en=%b want 0", bus_if.wr_en); end
        bus_if.ce = 1'b0;
    endtask

    // 23045 pixels -> 23040 writes, pending swap, vblank overrun, swap.
    task automatic test_full_frame();
        int nwr = 0;
        int bad = 0;
        logic [15:0] last_addr = '0;
        do_reset();
        start_frame();
        for (int i = 0; i < NPIX + 5; i++) begin
            bus_if.ce       = 1'b1;
            bus_if.pix_data = 15'(i * 7 + 3);
            step();
            if (bus_if.wr_en === 1'b1) begin
                nwr++;
                last_addr = bus_if.wr_addr;
                if (bus_if.wr_addr !== {1'b1, 15'(i)} || bus_if.wr_data !== 15'(i * 7 + 3)) bad++;
            end
        end
        bus_if.ce   = 1'b0;
        bus_if.mode = 2'b01;
        step();
        checks++;
        if (nwr != NPIX) begin errors++; $display("FAIL full_write_count: got %0d want %0d", nwr, NPIX); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_write_content: %0d bad writes want 0", bad); end
        checks++;
        if (last_addr !== {1'b1, 15'd23039}) begin errors++; $display("FAIL full_last_addr: got %h want %h", last_addr, {1'b1, 15'd23039}); end
        checks++;
        if (bus_if.swap_pend !== 1'b1 || bus_if.disp_bank !== 1'b0 || bus_if.wr_en !== 1'b0) begin
            errors++; $display("FAIL full_pend: got pend=%b bank=%b wr_en=%b want 1/0/0", bus_if.swap_pend, bus_if.disp_bank, bus_if.wr_en);
        end
        // Second vblank with no vsync: one skipped frame.
        bus_if.mode = 2'b00;
        step();
        bus_if.mode = 2'b01;
        step();
        step();
        checks++;
        if (bus_if.drop_cnt !== 8'd1) begin errors++; $display("FAIL pend_drop: got %0d want 1", bus_if.drop_cnt); end
        checks++;
        if (bus_if.swap_pend !== 1'b1 || bus_if.disp_bank !== 1'b0) begin
            errors++; $display("FAIL pend_hold: got pend=%b bank=%b want 1/0", bus_if.swap_pend, bus_if.disp_bank);
        end
        bus_if.disp_vsync = 1'b1;
        step();
        bus_if.disp_vsync = 1'b0;
        checks++;
        if (bus_if.disp_bank !== 1'b1 || bus_if.swap_pend !== 1'b0) begin
            errors++; $display("FAIL vsync_swap: got bank=%b pend=%b want 1/0", bus_if.disp_bank, bus_if.swap_pend);
        end
        // Next frame lands in the other bank, starting at index 0.
        bus_if.mode = 2'b00;
        step();
        bus_if.ce       = 1'b1;
        bus_if.pix_data = 15'h1ABC;
        step();
        bus_if.ce = 1'b0;
        checks++;
        if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== 16'h0000 || bus_if.wr_data !== 15'h1ABC) begin
            errors++; $display("FAIL bank0_first_write: got en=%b addr=%h data=%h want 1/0000/1abc", bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data);
        end
    endtask

    task automatic test_short_frame();
        int nwr = 0;
        do_reset();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            bus_if.ce       = 1'b1;
            bus_if.pix_data = 15'(i);
            step();
            if (bus_if.wr_en === 1'b1) nwr++;
        end
        bus_if.ce   = 1'b0;
        bus_if.mode = 2'b01;
        step();
        checks++;
        if (nwr != 100) begin errors++; $display("FAIL short_write_count: got %0d want 100", nwr); end
        checks++;
        if (bus_if.drop_cnt !== 8'd1 || bus_if.swap_pend !== 1'b0 || bus_if.disp_bank !== 1'b0) begin
            errors++; $display("FAIL short_drop: got drop=%0d pend=%b bank=%b want 1/0/0", bus_if.drop_cnt, bus_if.swap_pend, bus_if.disp_bank);
        end
        bus_if.mode = 2'b00;
        step();
        bus_if.ce       = 1'b1;
        bus_if.pix_data = 15'h1234;
        step();
        bus_if.ce = 1'b0;
        checks++;
        if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== 16'h8000 || bus_if.wr_data !== 15'h1234) begin
            errors++; $display("FAIL short_rearm: got en=%b addr=%h data=%h want 1/8000/1234", bus_if.wr_en, bus_if.wr_addr, bus_if.wr_data);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        start_frame();
        for (int i = 0; i < 10; i++) begin
            bus_if.ce = 1'b1;
            step();
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (bus_if.wr_en !== 1'b0) begin errors++; $display("FAIL midframe_reset_wr: got %b want 0", bus_if.wr_en); end
        bus_if.ce = 1'b0;
        start_frame();
        bus_if.ce       = 1'b1;
        bus_if.pix_data = 15'h0042;
        step();
        bus_if.ce = 1'b0;
        checks++;
        if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== 16'h8000) begin
            errors++; $display("FAIL midframe_restart: got en=%b addr=%h want 1/8000", bus_if.wr_en, bus_if.wr_addr);
        end
    endtask

    task automatic test_vsync_same_cycle();
        int nwr = 0;
        do_reset();
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            bus_if.ce       = 1'b1;
            bus_if.pix_data = 15'(i);
            step();
            if (bus_if.wr_en === 1'b1) nwr++;
        end
        bus_if.ce         = 1'b0;
        bus_if.mode       = 2'b01;
        bus_if.disp_vsync = 1'b1;
        step();
        bus_if.disp_vsync = 1'b0;
        checks++;
        if (nwr != NPIX) begin errors++; $display("FAIL same_write_count: got %0d want %0d", nwr, NPIX); end
        checks++;
        if (bus_if.disp_bank !== 1'b1 || bus_if.swap_pend !== 1'b0 || bus_if.drop_cnt !== 8'd0) begin
            errors++; $display("FAIL same_cycle_swap: got bank=%b pend=%b drop=%0d want 1/0/0", bus_if.disp_bank, bus_if.swap_pend, bus_if.drop_cnt);
        end
        step();
        checks++;
        if (bus_if.swap_pend !== 1'b0) begin errors++; $display("FAIL same_cycle_nopend: got %b want 0", bus_if.swap_pend); end
    endtask

    task automatic test_lcd_off();
        do_reset();
        start_frame();
        for (int i = 0; i < 50; i++) begin
            bus_if.ce = 1'b1;
            step();
        end
        bus_if.ce = 1'b0;
        step();
        bus_if.lcd_on = 1'b0;
        bus_if.ce     = 1'b1;
        step();
        checks++;
        if (bus_if.wr_en !== 1'b0) begin errors++; $display("FAIL lcd_fall_write: got %b want 0", bus_if.wr_en); end
`ifdef LCD_FB_BLANK_FILL_EN
        begin
            int bad = 0;
            for (int i = 0; i < NPIX; i++) begin
                if (i == 100) bus_if.lcd_on = 1'b1;
                step();
                if (bus_if.wr_en !== 1'b1 || bus_if.wr_addr !== {1'b1, 15'(i)} || bus_if.wr_data !== 15'h7FFF) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL fill_writes: %0d bad cycles want 0", bad); end
            checks++;
            if (bus_if.disp_bank !== 1'b1) begin errors++; $display("FAIL fill_swap: got bank=%b want 1", bus_if.disp_bank); end
            step();
            checks++;
            if (bus_if.wr_en !== 1'b0 || bus_if.drop_cnt !== 8'd0 || bus_if.swap_pend !== 1'b0) begin
                errors++; $display("FAIL fill_done: got en=%b drop=%0d pend=%b want 0/0/0", bus_if.wr_en, bus_if.drop_cnt, bus_if.swap_pend);
            end
        end
`else
        begin
            int nwr = 0;
            for (int i = 0; i < 200; i++) begin
                bus_if.mode = ((i % 20) < 5) ? 2'b01 : 2'b00;
                step();
                if (bus_if.wr_en === 1'b1) nwr++;
            end
            checks++;
            if (nwr != 0) begin errors++; $display("FAIL lcd_off_writes: got %0d want 0", nwr); end
            checks++;
            if (bus_if.disp_bank !== 1'b0 || bus_if.drop_cnt !== 8'd0 || bus_if.swap_pend !== 1'b0) begin
                errors++; $display("FAIL lcd_off_state: got bank=%b drop=%0d pend=%b want 0/0/0", bus_if.disp_bank, bus_if.drop_cnt, bus_if.swap_pend);
            end
        end
`endif
        bus_if.ce     = 1'b0;
        bus_if.mode   = 2'b00;
        bus_if.lcd_on = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_reset_midframe();
        test_vsync_same_cycle();
        test_lcd_off();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
